// File: rtl/sle_ctrl_pkg.sv
// Shared definitions for the SLE bank controller: opcodes, response codes,
// FSM states and the idle levels of the shared bank control lines.
package sle_ctrl_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_PRESET = 3'd3;
  localparam logic [2:0] OP_LATCH  = 3'd4;

  localparam logic [1:0] RSP_OK       = 2'd0;
  localparam logic [1:0] RSP_MISMATCH = 2'd1;
  localparam logic [1:0] RSP_ILLEGAL  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_VERIFY,
    ST_RESP
  } state_t;

  localparam logic IDLE_EN  = 1'b0;
  localparam logic IDLE_SLN = 1'b1;
  localparam logic IDLE_SD  = 1'b0;
  localparam logic IDLE_LAT = 1'b0;

  function automatic logic op_drives_bank(input logic [2:0] op);
    return (op >= OP_LOAD) && (op <= OP_LATCH);
  endfunction

endpackage

// File: rtl/sle_ctrl_timer.sv
// Loadable 4-bit down-counter timing the apply and settle windows.
// done is high in the last cycle of a window of load_val cycles.
module sle_ctrl_timer (
  input  logic       clk,
  input  logic       ALn,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge ALn) begin
    if (!ALn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign done = (cnt <= 4'd1);

endmodule

// File: rtl/sle_bank_ctrl.sv
// Command sequencer for a bank of SLE cells: applies a control pattern,
// waits to settle, verifies Q against the expected word, retries, responds.
module sle_bank_ctrl
  import sle_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 2,
  parameter int LAT_CYC    = 3,
  parameter int MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             ALn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] sle_d,
  output logic             sle_en,
  output logic             sle_sln,
  output logic             sle_sd,
  output logic             sle_lat,
  input  logic [WIDTH-1:0] sle_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_code,
  output logic [2:0]       rsp_retries
);

  localparam logic [3:0] SETTLE_LEN = 4'(SETTLE_CYC);
  localparam logic [3:0] LAT_LEN    = 4'(LAT_CYC);
  localparam logic [2:0] RETRY_MAX  = 3'(MAX_RETRY);

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] cmd_exp;
  logic [2:0]       retry;
  logic             accept;
  logic             q_match;
  logic             can_retry;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_done;
  logic [3:0]       tmr_val;

  function automatic logic [3:0] apply_len(input logic [2:0] op);
    return (op == OP_LATCH) ? LAT_LEN : 4'd1;
  endfunction

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign q_match   = (sle_q == exp_q);
  assign can_retry = (retry < RETRY_MAX);

  always_comb begin
    cmd_exp = '0;
    case (cmd_op)
      OP_LOAD, OP_LATCH: cmd_exp = cmd_data;
      OP_PRESET:         cmd_exp = '1;
      default:           cmd_exp = '0;
    endcase
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = 4'd1;
    case (state)
      ST_IDLE: begin
        if (accept && op_drives_bank(cmd_op)) begin
          tmr_load = 1'b1;
          tmr_val  = apply_len(cmd_op);
        end
      end
      ST_APPLY: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LEN;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SETTLE: tmr_dec = !tmr_done;
      ST_VERIFY: begin
        if (!q_match && can_retry) begin
          tmr_load = 1'b1;
          tmr_val  = apply_len(op_q);
        end
      end
      default: ;
    endcase
  end

  sle_ctrl_timer u_timer (
    .clk      (clk),
    .ALn      (ALn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  // Bank controls are registered from the current state, so each pattern
  // reaches the bank one cycle after the state that requests it.
  always_ff @(posedge clk or negedge ALn) begin
    if (!ALn) begin
      state       <= ST_IDLE;
      op_q        <= OP_NOP;
      data_q      <= '0;
      exp_q       <= '0;
      retry       <= '0;
      sle_d       <= '0;
      sle_en      <= IDLE_EN;
      sle_sln     <= IDLE_SLN;
      sle_sd      <= IDLE_SD;
      sle_lat     <= IDLE_LAT;
      rsp_valid   <= 1'b0;
      rsp_code    <= RSP_OK;
      rsp_retries <= '0;
    end else begin
      sle_en  <= IDLE_EN;
      sle_sln <= IDLE_SLN;
      sle_sd  <= IDLE_SD;
      sle_lat <= IDLE_LAT;
      if (state == ST_APPLY) begin
        sle_en <= 1'b1;
        case (op_q)
          OP_LOAD:   sle_d <= data_q;
          OP_CLEAR:  sle_sln <= 1'b0;
          OP_PRESET: begin
            sle_sln <= 1'b0;
            sle_sd  <= 1'b1;
          end
          OP_LATCH: begin
            sle_lat <= 1'b1;
            sle_d   <= data_q;
          end
          default: ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            exp_q  <= cmd_exp;
            retry  <= '0;
            if (op_drives_bank(cmd_op)) begin
              state <= ST_APPLY;
            end else begin
              state       <= ST_RESP;
              rsp_code    <= (cmd_op == OP_NOP) ? RSP_OK : RSP_ILLEGAL;
              rsp_retries <= '0;
            end
          end
        end
        ST_APPLY:  if (tmr_done) state <= ST_SETTLE;
        ST_SETTLE: if (tmr_done) state <= ST_VERIFY;
        ST_VERIFY: begin
          if (q_match) begin
            state       <= ST_RESP;
            rsp_code    <= RSP_OK;
            rsp_retries <= retry;
          end else if (can_retry) begin
            retry <= retry + 3'd1;
            state <= ST_APPLY;
          end else begin
            state       <= ST_RESP;
            rsp_code    <= RSP_MISMATCH;
            rsp_retries <= retry;
          end
        end
        ST_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            retry     <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sle_bank_ctrl.sv
// Directed bench for sle_bank_ctrl with an SLE bank model and a per-cycle
// timing model of the command schedule.
module tb_sle_bank_ctrl;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int L  = 3;
  localparam int MR = 2;

  logic         clk = 1'b0;
  logic         ALn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] sle_d;
  logic         sle_en;
  logic         sle_sln;
  logic         sle_sd;
  logic         sle_lat;
  logic [W-1:0] sle_q;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_code;
  logic [2:0]   rsp_retries;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sle_bank_ctrl #(.WIDTH(W), .SETTLE_CYC(S), .LAT_CYC(L), .MAX_RETRY(MR)) dut (
    .clk(clk), .ALn(ALn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .sle_d(sle_d), .sle_en(sle_en),
    .sle_sln(sle_sln), .sle_sd(sle_sd), .sle_lat(sle_lat), .sle_q(sle_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code),
    .rsp_retries(rsp_retries)
  );

  // SLE bank: cells capture on En; SLn low forces all cells to SD.
  logic [W-1:0] bank_q    = '0;
  logic         stuck     = 1'b0;
  logic [W-1:0] stuck_val = '0;

  always @(posedge clk) begin
    if (sle_en) begin
      if (!sle_sln) bank_q <= sle_sd ? '1 : '0;
      else          bank_q <= sle_d;
    end
  end
  assign sle_q = stuck ? stuck_val : bank_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Command plan: n = cycles per apply pulse, a = apply attempts,
  // r = cycle index (edges after accept) where rsp_valid must first be high.
  typedef struct packed {
    int         n;
    int         a;
    int         r;
    logic [1:0] code;
    logic [2:0] ret;
  } plan_t;

  function automatic plan_t mk_plan(input logic [2:0] op, input logic [W-1:0] data,
                                    input logic stk, input logic [W-1:0] sv);
    plan_t      p;
    logic [W-1:0] e;
    int         per;
    bit         pass;
    p.n = 0; p.a = 0; p.r = 1; p.code = 2'd0; p.ret = 3'd0;
    if (op > 3'd4) begin
      p.code = 2'd2;
    end else if (op != 3'd0) begin
      e      = (op == 3'd1 || op == 3'd4) ? data : (op == 3'd3) ? '1 : '0;
      p.n    = (op == 3'd4) ? L : 1;
      per    = p.n + S + 1;
      pass   = !stk || (e == sv);
      p.a    = pass ? 1 : MR + 1;
      p.r    = p.a * per + 1;
      p.code = pass ? 2'd0 : 2'd1;
      p.ret  = 3'(p.a - 1);
    end
    return p;
  endfunction

  function automatic bit in_win(input plan_t p, input int i);
    int per;
    per = p.n + S + 1;
    if (p.a == 0 || i < 1) return 1'b0;
    return (((i - 1) % per) < p.n) && (((i - 1) / per) < p.a);
  endfunction

  logic         m_busy = 1'b0;
  int           m_i    = 0;
  logic [2:0]   m_op   = '0;
  logic [W-1:0] m_data = '0;
  plan_t        m_plan;

  always @(posedge clk) begin
    if (!ALn) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (cmd_valid && cmd_ready) begin
        m_busy <= 1'b1;
        m_i    <= 0;
        m_op   <= cmd_op;
        m_data <= cmd_data;
        m_plan <= mk_plan(cmd_op, cmd_data, stuck, stuck_val);
      end
    end else begin
      m_i <= m_i + 1;
      if (rsp_valid && rsp_ready) m_busy <= 1'b0;
    end
  end

  int en_c = 0, sln_c = 0, sd_c = 0, lat_c = 0;

  always @(negedge clk) begin
    if (sle_en)   en_c++;
    if (!sle_sln) sln_c++;
    if (sle_sd)   sd_c++;
    if (sle_lat)  lat_c++;
    if (!ALn) begin
      chk("rst_en", sle_en, 0);     chk("rst_sln", sle_sln, 1);
      chk("rst_sd", sle_sd, 0);     chk("rst_lat", sle_lat, 0);
      chk("rst_d", sle_d, 0);       chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_code", rsp_code, 0); chk("rst_retries", rsp_retries, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
    end else if (!m_busy) begin
      chk("idle_en", sle_en, 0);   chk("idle_sln", sle_sln, 1);
      chk("idle_sd", sle_sd, 0);   chk("idle_lat", sle_lat, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_cmd_ready", cmd_ready, 1);
    end else begin
      chk("en", sle_en, in_win(m_plan, m_i));
      chk("lat", sle_lat, in_win(m_plan, m_i) && m_op == 3'd4);
      chk("sln", sle_sln, !(in_win(m_plan, m_i) && (m_op == 3'd2 || m_op == 3'd3)));
      chk("sd", sle_sd, in_win(m_plan, m_i) && m_op == 3'd3);
      if (in_win(m_plan, m_i) && (m_op == 3'd1 || m_op == 3'd4))
        chk("d", sle_d, m_data);
      chk("busy_cmd_ready", cmd_ready, 0);
      chk("rsp_valid", rsp_valid, m_i >= m_plan.r);
      if (m_i >= m_plan.r) begin
        chk("rsp_code", rsp_code, m_plan.code);
        chk("rsp_retries", rsp_retries, m_plan.ret);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] data, input int hold,
                      output int lat, output logic [1:0] code, output logic [2:0] ret);
    en_c = 0; sln_c = 0; sd_c = 0; lat_c = 0;
    cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
    code = rsp_code;
    ret  = rsp_retries;
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  int         lat;
  logic [1:0] code;
  logic [2:0] ret;

  initial begin
    ALn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom); cmd_op = 3'($urandom);
      cmd_data = W'($urandom);  rsp_ready = 1'($urandom);
    end
    chk("rst_ready_lit", cmd_ready, 1);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk); ALn = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("post_rst_ready", cmd_ready, 1);

    send(3'd1, 8'hA5, 0, lat, code, ret);
    chk("load_lat", lat, 5);  chk("load_en_c", en_c, 1);
    chk("load_q", bank_q, 8'hA5); chk("load_code", code, 0); chk("load_ret", ret, 0);

    send(3'd1, 8'hFF, 0, lat, code, ret);
    chk("loadff_q", bank_q, 8'hFF);
    send(3'd2, 8'h00, 0, lat, code, ret);
    chk("clr_q", bank_q, 8'h00); chk("clr_sln_c", sln_c, 1);
    chk("clr_sd_c", sd_c, 0);    chk("clr_code", code, 0);
    send(3'd3, 8'h00, 0, lat, code, ret);
    chk("pre_q", bank_q, 8'hFF); chk("pre_sd_c", sd_c, 1); chk("pre_code", code, 0);

    send(3'd4, 8'h3C, 0, lat, code, ret);
    chk("latch_lat_c", lat_c, 3); chk("latch_en_c", en_c, 3);
    chk("latch_q", bank_q, 8'h3C); chk("latch_lat", lat, 7); chk("latch_code", code, 0);

    stuck = 1'b1; stuck_val = 8'h00;
    send(3'd1, 8'h01, 0, lat, code, ret);
    chk("stuck_en_c", en_c, 3); chk("stuck_code", code, 1);
    chk("stuck_ret", ret, 2);   chk("stuck_lat", lat, 13);
    stuck = 1'b0;

    send(3'd6, 8'h77, 4, lat, code, ret);
    chk("ill_en_c", en_c, 0); chk("ill_lat_c", lat_c, 0);
    chk("ill_code", code, 2); chk("ill_lat", lat, 1);

    send(3'd0, 8'h00, 1, lat, code, ret);
    chk("nop_code", code, 0); chk("nop_lat", lat, 1); chk("nop_en_c", en_c, 0);

    cmd_op = 3'd4; cmd_data = 8'h5A; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    chk("midlatch_lat_hi", sle_lat, 1);
    ALn = 1'b0;
    #1;
    chk("abort_lat", sle_lat, 0); chk("abort_en", sle_en, 0);
    @(posedge clk); @(negedge clk); ALn = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("abort_no_rsp", rsp_valid, 0); chk("abort_ready", cmd_ready, 1);

    send(3'd1, 8'h5A, 0, lat, code, ret);
    chk("recover_q", bank_q, 8'h5A); chk("recover_lat", lat, 5); chk("recover_code", code, 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    chk("global_timeout", 1'b0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
